// File: rtl/cordic_angle_prep.sv
// Front end for the unrolled CORDIC cosine core: IEEE-754 single angle in,
// Q2.20 angle folded into [-pi/2, +pi/2] out, plus a cosine-negate flag.
module cordic_angle_prep #(
    parameter logic [21:0] PI_Q      = 22'h3243F6,
    parameter logic [21:0] HALF_PI_Q = 22'h1921FB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] angle_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [21:0] angle_out,
    output logic        cos_negate,
    output logic        range_err
);

    logic        advance;

    logic        s1_valid;
    logic        s1_sign;
    logic        s1_err;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mant;

    logic        s2_valid;
    logic        s2_sign;
    logic        s2_err;
    logic [21:0] s2_mag;

    logic [7:0]  shamt;
    logic [21:0] mag_c;
    logic        err_c;
    logic [21:0] red_c;
    logic        neg_c;
    logic [21:0] signed_c;

    // One shared enable: the whole pipe moves or the whole pipe holds.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_err   <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= angle_in[31];
            s1_err   <= (angle_in[30:23] == 8'hFF);
            s1_exp   <= angle_in[30:23];
            s1_mant  <= (angle_in[30:23] == 8'h00) ? 24'h0 : {1'b1, angle_in[22:0]};
        end
    end

    // Q2.20 magnitude = mant24 >> (3 - (e - 127)) = mant24 >> (130 - e).
    always_comb begin
        shamt = 8'd130 - s1_exp;
        mag_c = '0;
        err_c = s1_err;
        if (s1_exp >= 8'd129)
            err_c = 1'b1;
        else if (shamt < 8'd24)
            mag_c = 22'(s1_mant >> shamt[4:0]);
        if (mag_c > PI_Q)
            err_c = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_err   <= 1'b0;
            s2_mag   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_err   <= err_c;
            s2_mag   <= mag_c;
        end
    end

    // Fold about pi/2: cos(x) = -cos(pi - x).
    always_comb begin
        red_c = s2_mag;
        neg_c = 1'b0;
        if (s2_mag > HALF_PI_Q) begin
            red_c = PI_Q - s2_mag;
            neg_c = 1'b1;
        end
        signed_c = s2_sign ? (22'd0 - red_c) : red_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            angle_out  <= '0;
            cos_negate <= 1'b0;
            range_err  <= 1'b0;
        end else if (advance) begin
            out_valid  <= s2_valid;
            angle_out  <= s2_err ? 22'd0 : signed_c;
            cos_negate <= s2_err ? 1'b0 : neg_c;
            range_err  <= s2_err;
        end
    end

endmodule
